jtcop_palcopy: RTL and testbench
================================

JTCOP_PALCOPY -- requirements
Module: jtcop_palcopy

Interface
REQ-001 Parameter AW, default 10, palette word-address width (1024 entries).
REQ-002 clk  in  1  system clock; every register is clocked on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 LVBL  in  1  vertical blank, active-low, synchronous to clk.
REQ-005 cpu_cs  in  1  CPU palette access request; the CPU holds it until cpu_ack.
REQ-006 cpu_addr  in  AW  CPU word address (cpu_addr[AW:1] at the top level).
REQ-007 cpu_dout  in  16  CPU write data.
REQ-008 dsn  in  2  active-low byte strobes; dsn[1] upper byte, dsn[0] lower byte.
REQ-009 cpu_ack  out  1  single-cycle pulse when the CPU write has been performed.
REQ-010 sh_addr  out  AW  shadow palette RAM address.
REQ-011 sh_we  out  2  shadow RAM byte write enables.
REQ-012 sh_din  out  16  shadow RAM write data.
REQ-013 sh_dout  in  16  shadow RAM read data; synchronous, 1-cycle latency.
REQ-014 pal_addr  out  AW  active palette RAM write address.
REQ-015 pal_din  out  16  active palette RAM write data.
REQ-016 pal_we  out  2  active palette RAM byte write enables.
REQ-017 busy  out  1  high while a copy is in progress.
REQ-018 done  out  1  single-cycle pulse when a copy completes.

Function
REQ-019 All CPU writes target the shadow RAM only; the active palette changes only through copies.
REQ-020 A CPU request is accepted on the first cycle with cpu_cs high, the previous cpu_cs low, and the shadow port free.
  - Accept cycle: sh_addr=cpu_addr, sh_din=cpu_dout, sh_we=~dsn.
  - cpu_ack pulses on the next cycle.
REQ-021 A cpu_cs held high after cpu_ack does not cause a second write; a new write needs cpu_cs low for at least 1 cycle.
REQ-022 Any accepted CPU write with at least one strobe active sets the dirty flag.
REQ-023 LVBL is registered internally; a falling edge (1 to 0) while dirty=1 and the FSM is in IDLE starts a copy on the next cycle.
  - Starting a copy clears dirty.
  - A falling edge while dirty=0 is ignored.
REQ-024 FSM states and transitions:
  - IDLE -> RD on start.
  - RD: drives sh_addr=cnt with sh_we=0.
  - RD -> WR on the next cycle.
  - WR: drives pal_addr=cnt, pal_din=sh_dout, pal_we=2'b11.
  - WR -> RD with cnt+1 when cnt is below 2^AW-1.
  - WR -> IDLE with a done pulse when cnt equals 2^AW-1; cnt then wraps to 0.
REQ-025 Each word takes 2 cycles; a full copy with no CPU contention takes 2*2^AW cycles (2048 at AW=10).
REQ-026 CPU has priority on the shadow port.
  - A pending CPU request in a cycle where the FSM would enter RD is served instead.
  - The FSM holds in a stall cycle and issues RD on the next free cycle.
  - The WR cycle never needs the shadow port, so a CPU write may be accepted during WR.
REQ-027 CPU write stall is at most 1 cycle whatever the copy state.
REQ-028 A CPU write during a copy sets dirty again, so the next vblank recopies the whole palette.
REQ-029 If LVBL rises (vblank ends) before the copy finishes:
  - The copy aborts at the end of the current state: a pending WR completes, no new RD is issued.
  - FSM returns to IDLE, dirty is set, and no done pulse is generated.
REQ-030 busy is high from the first RD to the final WR inclusive.
REQ-031 pal_we is 0 whenever the FSM is not in WR; sh_we is 0 except on CPU accept cycles.

Reset
REQ-032 While rst_n=0, all outputs are 0.
  - State=IDLE, cnt=0, dirty=1 (first vblank after reset copies the shadow contents).
  - Registered LVBL=1 and registered cpu_cs=0.
REQ-033 Assertion mid-copy aborts the copy at once with no further pal_we; deassertion behaves as REQ-032.

Structure
REQ-034 A shared package holds the FSM state encoding (IDLE, RD, WR, STALL) and the default AW constant.
REQ-035 The block is a single module with no sub-modules; the edge detectors are inline registers.

Verification
REQ-036 Reset, write 0x0F0F to address 5 with dsn=00, pulse LVBL low -> pal_we at address 5 carries 0x0F0F; done pulses 2048 cycles after start; busy is low afterwards.
REQ-037 No CPU writes since the last copy, LVBL falls -> no RD cycles, no pal_we, busy stays 0.
REQ-038 CPU write with dsn=10 during an RD slot -> sh_we=01 that cycle and cpu_ack one cycle later; the copy finishes in 2049 cycles and dirty=1 afterwards.
REQ-039 cpu_cs held high for 10 cycles -> exactly one sh_we and exactly one cpu_ack.
REQ-040 LVBL rises at cycle 1000 of a copy -> the in-flight WR completes, then IDLE with no done; the next LVBL fall restarts the copy from address 0.
REQ-041 rst_n asserted mid-copy -> pal_we drops to 0 in the same cycle and all outputs read 0; after release and an LVBL fall, a full copy runs.

Source files
------------

// File: rtl/jtcop_palcopy_pkg.sv
// Shared definitions for the palette shadow-to-active copy engine.
// Holds the copy FSM state encoding and the default palette address width.
package jtcop_palcopy_pkg;

    localparam int PAL_AW = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        STALL = 2'd3
    } state_e;

endpackage

// File: rtl/jtcop_palcopy.sv
// Palette copy engine: CPU writes land in a shadow RAM, and the whole shadow
// is copied into the active palette during vertical blank when it is dirty.
module jtcop_palcopy
    import jtcop_palcopy_pkg::*;
#(
    parameter int AW = PAL_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          cpu_cs,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_dout,
    input  logic [1:0]    dsn,
    output logic          cpu_ack,
    output logic [AW-1:0] sh_addr,
    output logic [1:0]    sh_we,
    output logic [15:0]   sh_din,
    input  logic [15:0]   sh_dout,
    output logic [AW-1:0] pal_addr,
    output logic [15:0]   pal_din,
    output logic [1:0]    pal_we,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          dirty_q, dirty_d;
    logic          done_q, done_d;
    logic          ack_q;
    logic          lvbl_q;
    logic          cs_q;

    logic          cpu_accept;
    logic          lvbl_fall;

    // The CPU always wins the shadow port, so a new request is taken at once.
    // Gating with rst_n keeps sh_we quiet while reset is held.
    assign cpu_accept = rst_n & cpu_cs & ~cs_q;
    assign lvbl_fall  = lvbl_q & ~LVBL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dirty_q <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            lvbl_q  <= 1'b1;
            cs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
            done_q  <= done_d;
            ack_q   <= cpu_accept;
            lvbl_q  <= LVBL;
            cs_q    <= cpu_cs;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dirty_d  = dirty_q;
        done_d   = 1'b0;
        sh_addr  = '0;
        sh_we    = 2'b00;
        sh_din   = 16'h0000;
        pal_addr = '0;
        pal_din  = 16'h0000;
        pal_we   = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (lvbl_fall && dirty_q) begin
                    state_d = RD;
                    dirty_d = 1'b0;
                end
            end
            // STALL is a read slot retried after the CPU took the port
            RD, STALL: begin
                if (cpu_accept) begin
                    state_d = STALL;
                end else begin
                    sh_addr = cnt_q;
                    state_d = WR;
                end
            end
            WR: begin
                pal_addr = cnt_q;
                pal_din  = sh_dout;
                pal_we   = 2'b11;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (LVBL) begin
                    // vblank ended early: drop the copy and retry it next frame
                    state_d = IDLE;
                    dirty_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cpu_accept) begin
            sh_addr = cpu_addr;
            sh_din  = cpu_dout;
            sh_we   = ~dsn;
            if (dsn != 2'b11) begin
                dirty_d = 1'b1;
            end
        end
    end

    assign cpu_ack = ack_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_jtcop_palcopy.sv
// Directed bench for the palette copy engine with a shadow RAM model whose
// initial contents are addr ^ 16'hA5A5.
module tb_jtcop_palcopy;

    localparam int AW = 10;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          LVBL = 1'b1;
    logic          cpu_cs = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [15:0]   cpu_dout = 16'h0000;
    logic [1:0]    dsn = 2'b11;
    logic          cpu_ack;
    logic [AW-1:0] sh_addr;
    logic [1:0]    sh_we;
    logic [15:0]   sh_din;
    logic [15:0]   sh_dout;
    logic [AW-1:0] pal_addr;
    logic [15:0]   pal_din;
    logic [1:0]    pal_we;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    jtcop_palcopy #(.AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .LVBL     (LVBL),
        .cpu_cs   (cpu_cs),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .dsn      (dsn),
        .cpu_ack  (cpu_ack),
        .sh_addr  (sh_addr),
        .sh_we    (sh_we),
        .sh_din   (sh_din),
        .sh_dout  (sh_dout),
        .pal_addr (pal_addr),
        .pal_din  (pal_din),
        .pal_we   (pal_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Shadow RAM: byte-writable, synchronous read with one cycle of latency
    logic [15:0] shadow [N];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < N; i++) shadow[i] <= 16'(i) ^ 16'hA5A5;
            mem_init <= 1'b1;
        end else begin
            if (sh_we[0]) shadow[sh_addr][7:0]  <= sh_din[7:0];
            if (sh_we[1]) shadow[sh_addr][15:8] <= sh_din[15:8];
        end
        sh_dout <= shadow[sh_addr];
    end

    int          cyc = 0;
    int          pal_cnt = 0;
    int          sh_cnt = 0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          done_cyc = 0;
    int          busy_start = 0;
    int          last_pal_addr = -1;
    logic        busy_prev = 1'b0;
    logic [15:0] pal_model [N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pal_we != 2'b00) begin
            pal_cnt++;
            pal_model[pal_addr] = pal_din;
            last_pal_addr = int'(pal_addr);
        end
        if (sh_we != 2'b00) sh_cnt++;
        if (cpu_ack) ack_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (busy && !busy_prev) busy_start = cyc;
        busy_prev = busy;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] s,
                             output logic [1:0] we_seen, output logic ack_next);
        tick;
        cpu_cs = 1'b1;
        cpu_addr = a;
        cpu_dout = d;
        dsn = s;
        @(negedge clk);
        we_seen = sh_we;
        tick;
        @(negedge clk);
        ack_next = cpu_ack;
        tick;
        cpu_cs = 1'b0;
        dsn = 2'b11;
    endtask

    task automatic wait_done(input int limit, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cpu_cs = 1'b1;
        dsn = 2'b00;
        cpu_addr = 10'd5;
        cpu_dout = 16'hFFFF;
        LVBL = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_ack: got %b expected 0", cpu_ack); end
        checks++; if (sh_we !== 2'b00) begin errors++; $display("[TB] FAIL reset_sh_we: got %b expected 00", sh_we); end
        checks++; if (sh_addr !== '0) begin errors++; $display("[TB] FAIL reset_sh_addr: got %h expected 0", sh_addr); end
        checks++; if (sh_din !== 16'h0) begin errors++; $display("[TB] FAIL reset_sh_din: got %h expected 0", sh_din); end
        checks++; if (pal_we !== 2'b00) begin errors++; $display("[TB] FAIL reset_pal_we: got %b expected 00", pal_we); end
        checks++; if (pal_addr !== '0 || pal_din !== 16'h0) begin errors++; $display("[TB] FAIL reset_pal_bus: got %h/%h expected 0/0", pal_addr, pal_din); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        cpu_cs = 1'b0;
        dsn = 2'b11;
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_copy_basic;
        logic [1:0] we;
        logic ack, seen;
        int p0, d0;
        cpu_write(10'd5, 16'h0F0F, 2'b00, we, ack);
        checks++; if (we !== 2'b11) begin errors++; $display("[TB] FAIL basic_sh_we: got %b expected 11", we); end
        checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL basic_ack: got %b expected 1", ack); end
        p0 = pal_cnt;
        d0 = done_cnt;
        LVBL = 1'b0;
        wait_done(2200, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL basic_done_timeout: got %b expected 1", seen); end
        tick;
        checks++; if (done_cyc - busy_start != 2048) begin errors++; $display("[TB] FAIL basic_duration: got %0d expected 2048", done_cyc - busy_start); end
        checks++; if (pal_cnt - p0 != 1024) begin errors++; $display("[TB] FAIL basic_pal_writes: got %0d expected 1024", pal_cnt - p0); end
        checks++; if (pal_model[5] !== 16'h0F0F) begin errors++; $display("[TB] FAIL basic_pal5: got %h expected 0f0f", pal_model[5]); end
        checks++; if (pal_model[0] !== 16'hA5A5) begin errors++; $display("[TB] FAIL basic_pal0: got %h expected a5a5", pal_model[0]); end
        checks++; if (pal_model[1023] !== 16'hA65A) begin errors++; $display("[TB] FAIL basic_pal1023: got %h expected a65a", pal_model[1023]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
        tick;
        LVBL = 1'b1;
        repeat (3) tick;
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_no_dirty;
        int b0, p0;
        b0 = busy_cnt;
        p0 = pal_cnt;
        LVBL = 1'b0;
        repeat (20) tick;
        LVBL = 1'b1;
        repeat (3) tick;
        checks++; if (busy_cnt - b0 != 0) begin errors++; $display("[TB] FAIL clean_busy_cycles: got %0d expected 0", busy_cnt - b0); end
        checks++; if (pal_cnt - p0 != 0) begin errors++; $display("[TB] FAIL clean_pal_writes: got %0d expected 0", pal_cnt - p0); end
    endtask

    task automatic test_cpu_during_rd;
        logic [1:0] we;
        logic ack, seen, found;
        int p0;
        cpu_write(10'd700, 16'h1234, 2'b00, we, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rd_pre_ack: got %b expected 1", ack); end
        p0 = pal_cnt;
        LVBL = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (pal_we == 2'b11 && pal_addr == 10'd10) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL rd_wr10_timeout: got %b expected 1", found); end
        // this cycle is the read slot for word 11
        tick;
        cpu_cs = 1'b1;
        cpu_addr = 10'd9;
        cpu_dout = 16'hBEEF;
        dsn = 2'b10;
        @(negedge clk);
        checks++; if (sh_we !== 2'b01) begin errors++; $display("[TB] FAIL rd_sh_we: got %b expected 01", sh_we); end
        checks++; if (sh_addr !== 10'd9 || sh_din !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_sh_bus: got %h/%h expected 009/beef", sh_addr, sh_din); end
        checks++; if (pal_we !== 2'b00 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rd_slot_state: got pal_we=%b busy=%b expected 00/1", pal_we, busy); end
        tick;
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL rd_ack: got %b expected 1", cpu_ack); end
        checks++; if (sh_addr !== 10'd11 || sh_we !== 2'b00) begin errors++; $display("[TB] FAIL rd_retry: got addr=%h we=%b expected 00b/00", sh_addr, sh_we); end
        tick;
        cpu_cs = 1'b0;
        dsn = 2'b11;
        wait_done(2200, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rd_done_timeout: got %b expected 1", seen); end
        tick;
        checks++; if (done_cyc - busy_start != 2049) begin errors++; $display("[TB] FAIL rd_duration: got %0d expected 2049", done_cyc - busy_start); end
        checks++; if (pal_cnt - p0 != 1024) begin errors++; $display("[TB] FAIL rd_pal_writes: got %0d expected 1024", pal_cnt - p0); end
        checks++; if (pal_model[11] !== 16'hA5AE) begin errors++; $display("[TB] FAIL rd_pal11: got %h expected a5ae", pal_model[11]); end
        checks++; if (pal_model[9] !== 16'hA5AC) begin errors++; $display("[TB] FAIL rd_pal9_old: got %h expected a5ac", pal_model[9]); end
        checks++; if (pal_model[700] !== 16'h1234) begin errors++; $display("[TB] FAIL rd_pal700: got %h expected 1234", pal_model[700]); end
        LVBL = 1'b1;
        repeat (3) tick;
        LVBL = 1'b0;
        wait_done(2200, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rd_recopy_timeout: got %b expected 1", seen); end
        tick;
        checks++; if (pal_model[9] !== 16'hA5EF) begin errors++; $display("[TB] FAIL rd_pal9_new: got %h expected a5ef", pal_model[9]); end
        LVBL = 1'b1;
        repeat (3) tick;
    endtask

    task automatic test_cs_held;
        int s0, a0;
        s0 = sh_cnt;
        a0 = ack_cnt;
        cpu_cs = 1'b1;
        cpu_addr = 10'd3;
        cpu_dout = 16'h3333;
        dsn = 2'b00;
        repeat (10) tick;
        cpu_cs = 1'b0;
        dsn = 2'b11;
        repeat (3) tick;
        checks++; if (sh_cnt - s0 != 1) begin errors++; $display("[TB] FAIL held_sh_we_count: got %0d expected 1", sh_cnt - s0); end
        checks++; if (ack_cnt - a0 != 1) begin errors++; $display("[TB] FAIL held_ack_count: got %0d expected 1", ack_cnt - a0); end
    endtask

    task automatic test_abort;
        logic found, seen;
        int p0, d0, p1;
        p0 = pal_cnt;
        d0 = done_cnt;
        LVBL = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (busy) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL abort_start_timeout: got %b expected 1", found); end
        repeat (999) @(negedge clk);
        // vblank ends on copy cycle 1000, the read slot of word 500
        tick;
        LVBL = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL abort_idle_timeout: got %b expected 1", found); end
        tick;
        checks++; if (pal_cnt - p0 != 501) begin errors++; $display("[TB] FAIL abort_pal_writes: got %0d expected 501", pal_cnt - p0); end
        checks++; if (last_pal_addr != 500) begin errors++; $display("[TB] FAIL abort_last_addr: got %0d expected 500", last_pal_addr); end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt - d0); end
        repeat (3) tick;
        p1 = pal_cnt;
        d0 = done_cnt;
        LVBL = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (pal_we == 2'b11) found = 1'b1;
        end
        checks++; if (found !== 1'b1 || pal_addr !== 10'd0) begin errors++; $display("[TB] FAIL abort_restart_addr: got found=%b addr=%0d expected 1/0", found, pal_addr); end
        wait_done(2200, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL abort_recopy_timeout: got %b expected 1", seen); end
        tick;
        LVBL = 1'b1;
        repeat (3) tick;
        checks++; if (pal_cnt - p1 != 1024) begin errors++; $display("[TB] FAIL abort_recopy_writes: got %0d expected 1024", pal_cnt - p1); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL abort_recopy_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (pal_model[3] !== 16'h3333) begin errors++; $display("[TB] FAIL abort_pal3: got %h expected 3333", pal_model[3]); end
    endtask

    task automatic test_reset_mid_copy;
        logic [1:0] we;
        logic ack, found, seen;
        int p0;
        cpu_write(10'd12, 16'hC0DE, 2'b01, we, ack);
        checks++; if (we !== 2'b10) begin errors++; $display("[TB] FAIL rst_pre_sh_we: got %b expected 10", we); end
        LVBL = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pal_we == 2'b11) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL rst_wr_timeout: got %b expected 1", found); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (pal_we !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_pal_we: got %b expected 00", pal_we); end
        checks++; if ({cpu_ack, sh_we, busy, done} !== 5'b0 || sh_addr !== '0 || pal_addr !== '0 || pal_din !== 16'h0 || sh_din !== 16'h0)
            begin errors++; $display("[TB] FAIL rst_mid_outputs: got ack=%b sh_we=%b busy=%b done=%b pal_addr=%h pal_din=%h expected all 0", cpu_ack, sh_we, busy, done, pal_addr, pal_din); end
        p0 = pal_cnt;
        repeat (5) tick;
        LVBL = 1'b1;
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        checks++; if (pal_cnt - p0 != 0) begin errors++; $display("[TB] FAIL rst_no_pal_we: got %0d expected 0", pal_cnt - p0); end
        LVBL = 1'b0;
        wait_done(2200, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rst_copy_timeout: got %b expected 1", seen); end
        tick;
        checks++; if (done_cyc - busy_start != 2048) begin errors++; $display("[TB] FAIL rst_copy_duration: got %0d expected 2048", done_cyc - busy_start); end
        checks++; if (pal_cnt - p0 != 1024) begin errors++; $display("[TB] FAIL rst_copy_writes: got %0d expected 1024", pal_cnt - p0); end
        checks++; if (pal_model[12] !== 16'hC0A9) begin errors++; $display("[TB] FAIL rst_pal12: got %h expected c0a9", pal_model[12]); end
        LVBL = 1'b1;
        repeat (3) tick;
    endtask

    initial begin
        $display("[TB] starting jtcop_palcopy bench");
        test_reset;
        test_copy_basic;
        test_no_dirty;
        test_cpu_during_rd;
        test_cs_held;
        test_abort;
        test_reset_mid_copy;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
